// File: rtl/pattern_tx_fsm.sv
// Serial pattern transmitter.
// Latches a PAT_W-bit pattern and a repeat count on an accepted start, then shifts the pattern
// out MSB-first, one bit per clock, repeating it reps times with GAP idle cycles between
// repetitions. A one-cycle done pulse follows the last bit. All outputs are registered.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   start_i    transmit request, sampled only when idle
//   abort_i    synchronous cancel, honoured whenever not idle
//   pattern_i  pattern to send (MSB first), latched on accepted start
//   reps_i     number of pattern transmissions, latched on accepted start
//   data_out_o serial bit, 0 whenever valid_o is 0
//   valid_o    high while data_out_o carries a pattern bit
//   busy_o     high in every state except idle
//   done_o     one-cycle pulse after the last bit of the last repetition
module pattern_tx_fsm #(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [REP_W-1:0] reps_i,
  output logic             data_out_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(PAT_W);
  localparam int unsigned GapW = $clog2(GAP + 2);

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StShift = 4'b0010,
    StGap   = 4'b0100,
    StDone  = 4'b1000
  } state_e;

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] shreg_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [REP_W-1:0] rep_q;
  logic [GapW-1:0]  gap_cnt_q;
  logic             data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  // Remaining repetitions after the current one; saturates at zero.
  logic [REP_W-1:0] rep_dec;

  always_comb begin
    rep_dec = rep_q;
    if (rep_q != '0) begin
      rep_dec = rep_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      gap_cnt_q <= '0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            pat_q  <= pattern_i;
            rep_q  <= reps_i;
            busy_q <= 1'b1;
            if (reps_i != '0) begin
              // The MSB goes out directly so the first bit lands one cycle after start.
              state_q   <= StShift;
              data_q    <= pattern_i[PAT_W-1];
              valid_q   <= 1'b1;
              shreg_q   <= {pattern_i[PAT_W-2:0], 1'b0};
              bit_cnt_q <= CntW'(PAT_W - 1);
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              valid_q <= 1'b0;
              data_q  <= 1'b0;
            end
          end
        end
        StShift: begin
          if (abort_i) begin
            state_q <= StIdle;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bit_cnt_q != '0) begin
            data_q    <= shreg_q[PAT_W-1];
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end else begin
            // Bit 0 is on the line: this repetition is complete.
            rep_q <= rep_dec;
            if (rep_dec != '0) begin
              if (GAP == 0) begin
                data_q    <= pat_q[PAT_W-1];
                shreg_q   <= {pat_q[PAT_W-2:0], 1'b0};
                bit_cnt_q <= CntW'(PAT_W - 1);
              end else begin
                state_q   <= StGap;
                data_q    <= 1'b0;
                valid_q   <= 1'b0;
                gap_cnt_q <= GapW'(GAP - 1);
              end
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              data_q  <= 1'b0;
              valid_q <= 1'b0;
            end
          end
        end
        StGap: begin
          if (abort_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (gap_cnt_q == '0) begin
            state_q   <= StShift;
            data_q    <= pat_q[PAT_W-1];
            valid_q   <= 1'b1;
            shreg_q   <= {pat_q[PAT_W-2:0], 1'b0};
            bit_cnt_q <= CntW'(PAT_W - 1);
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        StDone: begin
          // Abort here lands in idle as well; done has already been shown.
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          data_q  <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_o = data_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
